// File: rtl/spi_shift_engine.sv
`default_nettype none
// ============================================================================
// spi_shift_engine : SPI mode-0 master shift engine, MSB first, CS-framed.
// Revision: 1.0
// ============================================================================
module spi_shift_engine #(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go_transfer,
   input  logic [DATA_W-1:0] data_write_to_spi,
   output logic [DATA_W-1:0] data_read_from_spi,
   output logic              data_pack_ready,
   output logic              busy,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              spi_cs_n
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   state_t              state_q, state_d;
   logic                go_q;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                sclk_q, sclk_d;
   logic                cs_n_q, cs_n_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                start;
   logic                tick;

   assign start = go_transfer & ~go_q;
   assign tick  = (div_q == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         go_q    <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         go_q    <= go_transfer;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      ready_d = 1'b0;
      busy_d  = busy_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tx_d    = data_write_to_spi;
               rx_d    = '0;
               div_d   = '0;
               bit_d   = '0;
               sclk_d  = 1'b0;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            if (tick) begin
               div_d   = '0;
               state_d = S_SHIFT;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         S_SHIFT: begin
            if (tick) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  // Rising SCLK edge: capture MISO into the LSB.
                  rx_d = (rx_q << 1) | DATA_W'(spi_miso);
               end else begin
                  tx_d  = tx_q << 1;
                  bit_d = bit_q + BIT_W'(1);
                  if (bit_q == BIT_LAST) begin
                     state_d = S_HOLD;
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         S_HOLD: begin
            if (tick) begin
               div_d   = '0;
               cs_n_d  = 1'b1;
               dout_d  = rx_q;
               ready_d = 1'b1;
               state_d = S_DONE;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            tx_d    = '0;
            rx_d    = '0;
            dout_d  = '0;
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            ready_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign data_read_from_spi = dout_q;
   assign data_pack_ready    = ready_q;
   assign busy               = busy_q;
   assign spi_sclk           = sclk_q;
   assign spi_cs_n           = cs_n_q;
   // MOSI is forced low outside the chip-select window.
   assign spi_mosi           = ~cs_n_q & tx_q[DATA_W-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_shift_engine : bench for spi_shift_engine (CLK_DIV=2 and CLK_DIV=1).
// Revision: 1.0
// ============================================================================
module tb_spi_shift_engine;

   localparam int W     = 32;
   localparam int D0    = 2;
   localparam int LAST0 = (2 * W + 2) * D0;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: CLK_DIV=2
   logic          go0 = 1'b0;
   logic [W-1:0]  wdata0 = '0;
   logic [W-1:0]  rdata0;
   logic          rdy0, busy0, sclk0, mosi0, miso0, cs_n0;
   logic          loopback = 1'b1;
   logic [W-1:0]  slave_word = '0;
   logic [W-1:0]  s_sr = '0;
   logic          s_prev = 1'b0;

   // Instance 1: CLK_DIV=1, MOSI looped back
   logic          go1 = 1'b0;
   logic [W-1:0]  wdata1 = '0;
   logic [W-1:0]  rdata1;
   logic          rdy1, busy1, sclk1, mosi1, cs_n1;

   spi_shift_engine #(.CLK_DIV(2), .DATA_W(W)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .go_transfer(go0),
      .data_write_to_spi(wdata0), .data_read_from_spi(rdata0),
      .data_pack_ready(rdy0), .busy(busy0), .spi_sclk(sclk0),
      .spi_mosi(mosi0), .spi_miso(miso0), .spi_cs_n(cs_n0)
   );

   spi_shift_engine #(.CLK_DIV(1), .DATA_W(W)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .go_transfer(go1),
      .data_write_to_spi(wdata1), .data_read_from_spi(rdata1),
      .data_pack_ready(rdy1), .busy(busy1), .spi_sclk(sclk1),
      .spi_mosi(mosi1), .spi_miso(mosi1), .spi_cs_n(cs_n1)
   );

   // Mode-0 slave: present MSB at CS low, advance after each SCLK fall.
   assign miso0 = loopback ? mosi0 : s_sr[W-1];
   always @(negedge clk) begin
      s_prev <= sclk0;
      if (cs_n0) s_sr <= slave_word;
      else if (s_prev && !sclk0) s_sr <= s_sr << 1;
   end

   // Free-running waveform monitors; stimulus compares differences.
   int cs_low0 = 0, rise0 = 0, rdyc0 = 0, busyc0 = 0, busyr0 = 0;
   logic [W-1:0] mosi_cap0 = '0;
   logic sclk_p0 = 1'b0, busy_p0 = 1'b0;
   int cs_low1 = 0, rise1 = 0, rdyc1 = 0, perbad1 = 0, cyc = 0, last_rise1 = 0;
   logic sclk_p1 = 1'b0, have_rise1 = 1'b0;

   always @(negedge clk) begin
      cyc     <= cyc + 1;
      sclk_p0 <= sclk0;
      busy_p0 <= busy0;
      if (cs_n0 === 1'b0) cs_low0 <= cs_low0 + 1;
      if (sclk0 === 1'b1 && !sclk_p0) begin
         rise0     <= rise0 + 1;
         mosi_cap0 <= {mosi_cap0[W-2:0], mosi0};
      end
      if (rdy0 === 1'b1) rdyc0 <= rdyc0 + 1;
      if (busy0 === 1'b1) busyc0 <= busyc0 + 1;
      if (busy0 === 1'b1 && !busy_p0) busyr0 <= busyr0 + 1;

      sclk_p1 <= sclk1;
      if (cs_n1 === 1'b0) cs_low1 <= cs_low1 + 1;
      if (rdy1 === 1'b1) rdyc1 <= rdyc1 + 1;
      if (cs_n1 !== 1'b0) have_rise1 <= 1'b0;
      else if (sclk1 === 1'b1 && !sclk_p1) begin
         rise1 <= rise1 + 1;
         if (have_rise1 && (cyc - last_rise1) != 2) perbad1 <= perbad1 + 1;
         last_rise1 <= cyc;
         have_rise1 <= 1'b1;
      end
   end

   // Transaction-level model of instance 0: k = cycles since acceptance.
   int           m_k = -1;
   logic         m_go_prev = 1'b0;
   logic [W-1:0] m_tx = '0, m_rx = '0, m_dout = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_k <= -1; m_go_prev <= 1'b0; m_tx <= '0; m_rx <= '0; m_dout <= '0;
      end else begin
         m_go_prev <= go0;
         if (m_k == -1) begin
            if (go0 && !m_go_prev) begin
               m_k  <= 0;
               m_tx <= wdata0;
               m_rx <= loopback ? wdata0 : slave_word;
            end
         end else if (m_k == LAST0) begin
            m_k <= -1;
         end else begin
            m_k <= m_k + 1;
            if (m_k == LAST0 - 1) m_dout <= m_rx;
         end
      end
   end

   int n_tests = 0, n_fail = 0, n_model_print = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_cycle();
      logic e_cs, e_sclk, e_mosi, e_busy, e_rdy;
      int j;
      e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_rdy = 1'b0;
      if (m_k >= 0 && m_k < LAST0) begin
         e_cs = 1'b0; e_busy = 1'b1;
         if (m_k < D0) e_mosi = m_tx[W-1];
         else begin
            j = (m_k - D0) / D0;
            if (j < 2 * W) e_sclk = j[0];
            if (j / 2 < W) e_mosi = m_tx[W - 1 - j / 2];
         end
      end else if (m_k == LAST0) begin
         e_busy = 1'b1; e_rdy = 1'b1;
      end
      n_tests++;
      if ({cs_n0, sclk0, mosi0, busy0, rdy0} !== {e_cs, e_sclk, e_mosi, e_busy, e_rdy}
          || rdata0 !== m_dout) begin
         n_fail++;
         if (n_model_print < 20) begin
            n_model_print++;
            $display("FAIL model_cycle k=%0d: got cs_n/sclk/mosi/busy/rdy=%b%b%b%b%b rd=%h expected %b%b%b%b%b rd=%h",
                     m_k, cs_n0, sclk0, mosi0, busy0, rdy0, rdata0,
                     e_cs, e_sclk, e_mosi, e_busy, e_rdy, m_dout);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready0(input string name);
      int n = 0;
      while (rdy0 !== 1'b1 && n < 1000) begin tick(1); n++; end
      n_tests++;
      if (rdy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: got no data_pack_ready after %0d cycles, expected one", name, n);
      end
   endtask

   int s_cs, s_rise, s_rdy, s_busy, s_busyr;

   task automatic snap0();
      s_cs = cs_low0; s_rise = rise0; s_rdy = rdyc0; s_busy = busyc0; s_busyr = busyr0;
   endtask

   task automatic start0(input logic [W-1:0] d, input logic lb, input logic [W-1:0] sw);
      wdata0 = d; loopback = lb; slave_word = sw;
      snap0();
      go0 = 1'b1;
      tick(1);
      go0 = 1'b0;
   endtask

   task automatic check_xfer(input string name, input logic [W-1:0] exp_rd);
      wait_ready0(name);
      tick(2);
      chk({name, "_cs_low"}, W'(cs_low0 - s_cs), 32'd132);
      chk({name, "_rises"},  W'(rise0 - s_rise), 32'd32);
      chk({name, "_ready"},  W'(rdyc0 - s_rdy), 32'd1);
      chk({name, "_rdata"},  rdata0, exp_rd);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            compare_cycle();
         end
      join_none

      tick(4);
      chk("reset_outputs0", W'({cs_n0, sclk0, mosi0, busy0, rdy0}), W'(5'b10000));
      chk("reset_rdata0", rdata0, 32'h0);
      chk("reset_outputs1", W'({cs_n1, sclk1, mosi1, busy1, rdy1}), W'(5'b10000));
      reset_n = 1'b1;
      tick(5);

      // Loopback
      start0(32'hA5A5A5A5, 1'b1, 32'h0);
      check_xfer("loopback", 32'hA5A5A5A5);
      chk("loopback_mosi", mosi_cap0, 32'hA5A5A5A5);

      // Independent slave data
      start0(32'hDEADBEEF, 1'b0, 32'h12345678);
      check_xfer("slave", 32'h12345678);
      chk("slave_mosi", mosi_cap0, 32'hDEADBEEF);

      // Long go level plus a second pulse near bit 5
      wdata0 = 32'h0F0F1234; loopback = 1'b1;
      snap0();
      go0 = 1'b1; tick(7); go0 = 1'b0;
      tick(16);
      go0 = 1'b1; tick(1); go0 = 1'b0;
      check_xfer("long_go", 32'h0F0F1234);
      chk("long_go_busy_cycles", W'(busyc0 - s_busy), 32'd133);
      chk("long_go_busy_rises", W'(busyr0 - s_busyr), 32'd1);

      // Reset near bit 10
      start0(32'h55AA33CC, 1'b1, 32'h0);
      tick(41);
      reset_n = 1'b0;
      #1;
      chk("midreset_outputs", W'({cs_n0, sclk0, mosi0, busy0, rdy0}), W'(5'b10000));
      chk("midreset_rdata", rdata0, 32'h0);
      tick(2);
      reset_n = 1'b1;
      tick(5);
      chk("midreset_no_ready", W'(rdyc0 - s_rdy), 32'd0);
      start0(32'h13579BDF, 1'b1, 32'h0);
      check_xfer("after_reset", 32'h13579BDF);

      // go rising during the ready cycle is dropped
      start0(32'h2468ACE0, 1'b1, 32'h0);
      wait_ready0("ready_cycle");
      go0 = 1'b1; tick(1); go0 = 1'b0;
      snap0();
      tick(10);
      chk("ready_cycle_ignored_busy", W'(busy0), 32'd0);
      chk("ready_cycle_ignored_cs", W'(cs_low0 - s_cs), 32'd0);

      // go rising one cycle after the ready pulse is taken
      start0(32'h3C3C5A5A, 1'b1, 32'h0);
      wait_ready0("next_cycle_a");
      tick(1);
      snap0();
      wdata0 = 32'hC3C3A5A5;
      go0 = 1'b1; tick(1); go0 = 1'b0;
      check_xfer("next_cycle", 32'hC3C3A5A5);

      // CLK_DIV=1 instance
      begin
         int n, c1, r1, k1;
         c1 = cs_low1; r1 = rise1; k1 = rdyc1; n = 0;
         wdata1 = 32'h00000001;
         go1 = 1'b1; tick(1); go1 = 1'b0;
         while (rdy1 !== 1'b1 && n < 500) begin tick(1); n++; end
         chk("div1_ready_seen", W'(rdy1), 32'd1);
         tick(2);
         chk("div1_cs_low", W'(cs_low1 - c1), 32'd66);
         chk("div1_rises", W'(rise1 - r1), 32'd32);
         chk("div1_ready", W'(rdyc1 - k1), 32'd1);
         chk("div1_period_errors", W'(perbad1), 32'd0);
         chk("div1_rdata", rdata1, 32'h00000001);
      end

      tick(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bits per transfer.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port go_transfer  input  1  transfer request from the Avalon slave; may stay high for several cycles.
REQ-006 SHALL have port data_write_to_spi  input  DATA_W  word to transmit.
REQ-007 SHALL have port data_read_from_spi  output  DATA_W  last received word, registered.
REQ-008 SHALL have port data_pack_ready  output  1  one-cycle transfer-complete pulse.
REQ-009 SHALL have port busy  output  1  high from transfer acceptance until the data_pack_ready pulse, inclusive.
REQ-010 SHALL have port spi_sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have port spi_mosi  output  1  serial data out, MSB first.
REQ-012 SHALL have port spi_miso  input  1  serial data in, MSB first.
REQ-013 SHALL have port spi_cs_n  output  1  active-low slave select.

Function
REQ-014 SHALL register go_transfer once and detect start as go_transfer & ~go_transfer_d; level-high or repeated-high go yields one transfer only.
REQ-015 SHALL implement states IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-016 IDLE: on start, SHALL latch data_write_to_spi into tx shift register, drive spi_cs_n=0, busy=1, clear bit and divider counters, and enter SETUP on the next edge.
REQ-017 SHALL ignore start in SETUP, SHIFT, HOLD, DONE; no queuing.
REQ-018 SETUP SHALL last CLK_DIV cycles with spi_sclk=0 and spi_mosi = tx[DATA_W-1].
REQ-019 SHIFT SHALL toggle spi_sclk every CLK_DIV cycles, starting low, for exactly 2*DATA_W half-periods.
REQ-020 On each spi_sclk rising transition SHALL shift spi_miso into the LSB of the rx register.
REQ-021 On each spi_sclk falling transition SHALL shift tx left by one, so spi_mosi presents the next bit.
REQ-022 After the DATA_W-th falling transition SHALL enter HOLD with spi_sclk=0 for CLK_DIV cycles.
REQ-023 On HOLD exit SHALL drive spi_cs_n=1, load data_read_from_spi from rx, pulse data_pack_ready for exactly one cycle (DONE), then return to IDLE with busy=0.
REQ-024 spi_cs_n SHALL be low for exactly (2*DATA_W+2)*CLK_DIV clk cycles per transfer (132 at defaults).
REQ-025 data_read_from_spi SHALL change only in DONE and hold its value otherwise.
REQ-026 spi_mosi SHALL be 0 whenever spi_cs_n=1.
REQ-027 The divider counter SHALL be width ceil(log2(CLK_DIV+1)) and wrap to 0 at CLK_DIV-1; the bit counter SHALL count 0..DATA_W without overflow.
REQ-028 Start sampled in the same cycle as data_pack_ready SHALL be ignored; start one cycle after SHALL be accepted.
REQ-029 Illegal state encodings SHALL return to IDLE with outputs at reset values.

Reset
REQ-030 reset_n low SHALL immediately force spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, data_pack_ready=0, data_read_from_spi=0, state IDLE, all counters and shift registers 0, go_transfer_d=0.
REQ-031 Reset mid-transfer SHALL abort without a data_pack_ready pulse; reset deassertion SHALL be synchronous to clk.

Verification
REQ-032 Loopback spi_mosi->spi_miso, CLK_DIV=2, write 32'hA5A5A5A5, single-cycle go -> exactly 32 SCLK rising edges, cs_n low 132 cycles, data_read_from_spi=32'hA5A5A5A5, one-cycle data_pack_ready.
REQ-033 Send 32'hDEADBEEF while slave model drives 32'h12345678 -> MOSI bits sampled on SCLK rising edges equal DEADBEEF MSB first; data_read_from_spi=32'h12345678.
REQ-034 go_transfer high for 7 cycles, then a second pulse at bit 5 -> exactly one transfer, busy continuous, one data_pack_ready.
REQ-035 reset_n low at bit 10 -> same-cycle cs_n=1, sclk=0, busy=0, data_read_from_spi=0, no pack-ready; a subsequent go completes normally.
REQ-036 go rising on the data_pack_ready cycle -> ignored; go rising one cycle later -> accepted, cs_n low again 132 cycles.
REQ-037 CLK_DIV=1 -> SCLK period 2 clk cycles, cs_n low 66 cycles, loopback of 32'h00000001 returns 32'h00000001.
